// File: rtl/sim_status_mmio_if.sv
// Data-memory bus and console-drain signals shared between the CPU/bench side
// and the status/console slave.
interface sim_status_mmio_if;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [31:0] rdata;
  logic        hit;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;

  modport master (
    output dmem_addr, dmem_wdata, dmem_we, con_ready,
    input  rdata, hit, con_valid, con_data
  );

  modport slave (
    input  dmem_addr, dmem_wdata, dmem_we, con_ready,
    output rdata, hit, con_valid, con_data
  );
endinterface

// File: rtl/sim_status_mmio.sv
// Test-status/console slave: captures tohost exit writes, buffers console bytes
// for the bench, and runs cycle/stall watchdogs that force a timeout halt.
module sim_status_mmio #(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_1000,
  parameter int          FIFO_DEPTH     = 16,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          STALL_LIMIT    = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            pc,
  sim_status_mmio_if.slave       bus,
  output logic                   halt,
  output logic                   pass,
  output logic [30:0]            exit_code,
  output logic                   timeout,
  output logic [31:0]            cycle_count
);
  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam int          STALL_W   = $clog2(STALL_LIMIT) + 1;
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic               overflow_q;
  logic [STALL_W-1:0] stall_cnt_q;
  logic [31:0]        pc_prev_q;
  logic [7:0]         mem [FIFO_DEPTH];

  logic [29:0] word_off;
  logic        sel_tohost, sel_con, sel_cycle;
  logic        wr_en, tohost_exit, push, pop, full, push_acc, wd_trip;
  logic [7:0]  count8;
  logic        unused_addr_lsb;

  // Address decode: word offset from the window base, low two bits ignored
  assign word_off        = bus.dmem_addr[31:2] - BASE_WORD;
  assign bus.hit         = (word_off < 30'd3);
  assign sel_tohost      = bus.hit && (word_off[1:0] == 2'd0);
  assign sel_con         = bus.hit && (word_off[1:0] == 2'd1);
  assign sel_cycle       = bus.hit && (word_off[1:0] == 2'd2);
  assign unused_addr_lsb = ^bus.dmem_addr[1:0];

  assign wr_en       = bus.dmem_we && (state_q == RUN);
  assign tohost_exit = wr_en && sel_tohost && bus.dmem_wdata[0];
  assign push        = wr_en && sel_con;
  assign pop         = bus.con_valid && bus.con_ready;
  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  // A push into a full FIFO only fits if the head leaves on the same edge
  assign push_acc    = push && (!full || pop);
  assign wd_trip     = (state_q == RUN) &&
                       ((stall_cnt_q == STALL_W'(STALL_LIMIT - 1)) ||
                        (cycle_count == 32'(TIMEOUT_CYCLES - 1)));

  assign bus.con_valid = (count_q != '0);
  assign bus.con_data  = bus.con_valid ? mem[rd_ptr_q] : 8'h00;
  assign halt          = (state_q == DONE);
  assign pass          = halt && !timeout && (exit_code == 31'd0);
  assign count8        = 8'(count_q);

  always_comb begin
    bus.rdata = 32'h0;
    if (sel_tohost)     bus.rdata = {exit_code, halt};
    else if (sel_con)   bus.rdata = {23'b0, overflow_q, count8};
    else if (sel_cycle) bus.rdata = cycle_count;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (tohost_exit || wd_trip) state_d = DRAIN;
      DRAIN:   if (count_q == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      exit_code   <= 31'd0;
      timeout     <= 1'b0;
      cycle_count <= 32'd0;
      stall_cnt_q <= '0;
      pc_prev_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN) begin
        // A tohost exit wins over a watchdog trip in the same cycle
        if (tohost_exit) begin
          exit_code <= bus.dmem_wdata[31:1];
        end else if (wd_trip) begin
          timeout   <= 1'b1;
          exit_code <= 31'd0;
        end
        pc_prev_q   <= pc;
        stall_cnt_q <= (pc != pc_prev_q) ? '0 : stall_cnt_q + STALL_W'(1);
      end
      if (state_q != DONE && cycle_count != 32'hFFFF_FFFF)
        cycle_count <= cycle_count + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_q + CNT_W'(push_acc) - CNT_W'(pop);
      if (push_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !push_acc) overflow_q <= 1'b1;
    end
  end

  // Storage carries data only; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_q] <= bus.dmem_wdata[7:0];
  end
endmodule

// File: tb/tb_sim_status_mmio.sv
// Directed bench for sim_status_mmio: console bytes are checked by a scoreboard
// monitor, status outputs by direct comparisons against hand-computed values.
module tb_sim_status_mmio;
  localparam logic [31:0] BASE  = 32'h8000_1000;
  localparam int          DEPTH = 16;
  localparam int          STALL = 32;
  localparam int          TMO   = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'd0;
  logic        pc_run = 1'b0;
  logic        halt, pass, timeout;
  logic [30:0] exit_code;
  logic [31:0] cycle_count;

  int nchecks = 0;
  int nerr = 0;
  logic [7:0] sb[$];

  sim_status_mmio_if bus();

  sim_status_mmio #(
    .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .STALL_LIMIT(STALL)
  ) dut (
    .clk(clk), .reset(reset), .pc(pc), .bus(bus),
    .halt(halt), .pass(pass), .exit_code(exit_code),
    .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (pc_run) pc = pc + 32'd4;
  end

  // Console monitor: a handshake seen at negedge completes on the next rising edge
  always @(negedge clk) begin
    if (!reset && bus.con_valid && bus.con_ready) begin
      nchecks++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL con_pop: got %h, expected no byte", bus.con_data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (bus.con_data !== e) begin
          nerr++;
          $display("FAIL con_pop: got %h expected %h", bus.con_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.dmem_addr  = a;
    bus.dmem_wdata = d;
    bus.dmem_we    = 1'b1;
    tick(1);
    bus.dmem_we    = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_kept);
    if (expect_kept) sb.push_back(b);
    wr(BASE + 32'd4, {24'h0, b});
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.dmem_addr = a;
    bus.dmem_we   = 1'b0;
    #1;
    chk(name, bus.rdata, exp);
  endtask

  task automatic do_reset();
    bus.dmem_we   = 1'b0;
    bus.con_ready = 1'b0;
    bus.dmem_addr = 32'h0;
    bus.dmem_wdata = 32'h0;
    reset = 1'b1;
    sb.delete();
    tick(2);
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    bus.con_ready = 1'b1;
    for (int i = 0; i < budget && sb.size() != 0; i++) tick(1);
    chk("drain_left", sb.size(), 0);
    bus.con_ready = 1'b0;
  endtask

  initial begin
    bus.dmem_we = 1'b0;
    bus.con_ready = 1'b0;
    bus.dmem_addr = 32'h0;
    bus.dmem_wdata = 32'h0;

    // Test 1: reset state, ignored tohost write, clean exit
    pc_run = 1'b1;
    reset = 1'b1;
    tick(2);
    chk("rst_halt", halt, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_exit", exit_code, 0);
    chk("rst_cycle", cycle_count, 0);
    chk("rst_con_valid", bus.con_valid, 0);
    do_reset();
    wr(BASE, 32'h2);
    tick(2);
    chk("t1_even_ignored", halt, 0);
    wr(BASE, 32'h1);
    chk("t1_drain_halt", halt, 0);
    tick(1);
    chk("t1_halt", halt, 1);
    chk("t1_pass", pass, 1);
    chk("t1_exit", exit_code, 0);
    chk("t1_timeout", timeout, 0);
    rd("t1_rd_tohost", BASE, 32'h1);
    push_byte(8'h55, 1'b0);
    chk("t1_done_push_dropped", bus.con_valid, 0);
    tick(3);
    chk("t1_cycle_frozen", cycle_count, 5);
    rd("t1_rd_cycle", BASE + 32'd8, 32'd5);

    // Test 2: 'H','i' held while not ready, then drained in order
    do_reset();
    push_byte(8'h48, 1'b1);
    chk("t2_latency_valid", bus.con_valid, 1);
    push_byte(8'h69, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("t2_hold_valid", bus.con_valid, 1);
      chk("t2_hold_data", bus.con_data, 8'h48);
    end
    drain(10);
    chk("t2_empty_valid", bus.con_valid, 0);

    // Test 3: fill, full push with pop, full push without pop (overflow)
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h10 + i), 1'b1);
    rd("t3_full_no_ovf", BASE + 32'd4, 32'h0000_0010);
    bus.con_ready = 1'b1;
    push_byte(8'hA5, 1'b1);
    bus.con_ready = 1'b0;
    rd("t3_full_pushpop", BASE + 32'd4, 32'h0000_0010);
    chk("t3_head_after_pop", bus.con_data, 8'h11);
    push_byte(8'hEE, 1'b0);
    rd("t3_overflow", BASE + 32'd4, 32'h0000_0110);
    drain(40);
    rd("t3_sticky_ovf", BASE + 32'd4, 32'h0000_0100);

    // Test 4: exit with bytes queued stays in DRAIN until empty
    do_reset();
    push_byte(8'h31, 1'b1);
    push_byte(8'h32, 1'b1);
    push_byte(8'h33, 1'b1);
    wr(BASE, 32'h7);
    push_byte(8'h99, 1'b0);
    tick(3);
    chk("t4_drain_hold", halt, 0);
    rd("t4_drain_count", BASE + 32'd4, 32'h0000_0003);
    drain(20);
    for (int i = 0; i < 10 && !halt; i++) tick(1);
    chk("t4_halt", halt, 1);
    chk("t4_pass", pass, 0);
    chk("t4_exit", exit_code, 3);
    chk("t4_timeout", timeout, 0);
    chk("t4_no_extra", bus.con_valid, 0);

    // Test 5a: constant pc trips the stall watchdog
    pc_run = 1'b0;
    pc = 32'd0;
    do_reset();
    tick(STALL);
    chk("t5a_pre_halt", halt, 0);
    tick(1);
    chk("t5a_halt", halt, 1);
    chk("t5a_timeout", timeout, 1);
    chk("t5a_pass", pass, 0);
    chk("t5a_exit", exit_code, 0);
    chk("t5a_cycle", cycle_count, STALL + 1);

    // Test 5b: moving pc trips the cycle watchdog
    pc_run = 1'b1;
    do_reset();
    tick(TMO);
    chk("t5b_pre_halt", halt, 0);
    tick(1);
    chk("t5b_halt", halt, 1);
    chk("t5b_timeout", timeout, 1);
    chk("t5b_cycle", cycle_count, TMO + 1);

    // Test 6: asynchronous reset during DRAIN discards queued bytes
    do_reset();
    push_byte(8'h41, 1'b1);
    push_byte(8'h42, 1'b1);
    wr(BASE, 32'h1);
    tick(1);
    chk("t6_in_drain", halt, 0);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("t6_con_valid", bus.con_valid, 0);
    chk("t6_halt", halt, 0);
    chk("t6_cycle", cycle_count, 0);
    rd("t6_rd_cycle", BASE + 32'd8, 32'h0);
    chk("t6_hit", bus.hit, 1);
    tick(1);
    reset = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
